// File: rtl/param_sync_fifo.sv
// ============================================================================
// param_sync_fifo : single-clock parameterised FIFO, registered or FWFT read
// Revision 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module param_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] head;
  logic             rd_acc;
  logic             wr_acc;

  // A write into a full FIFO is allowed when the same cycle frees a slot.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_en);
  assign head   = mem[rd_ptr[AW-1:0]];

  assign full         = (count == PW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= PW'(AF_THRESH));
  assign almost_empty = (count <= PW'(AE_THRESH));

  always_ff @(posedge clk) begin
    if (!reset && !clear && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && empty;
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q <= '0;
        end else if (!clear && rd_acc) begin
          dout_q <= head;
        end
      end
      assign data_out = dout_q;
    end else begin : g_fwft_read
      // Track the presented head so the output holds it once the FIFO drains.
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q <= '0;
        end else if (!empty) begin
          dout_q <= head;
        end
      end
      assign data_out = empty ? dout_q : head;
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the data word width in bits (range 1..64).
REQ-002 The parameter DEPTH SHALL default to 16 and set the number of entries (power of 2, at least 2).
REQ-003 The parameter AF_THRESH SHALL default to DEPTH-2 and set the almost_full level (range 1..DEPTH).
REQ-004 The parameter AE_THRESH SHALL default to 2 and set the almost_empty level (range 0..DEPTH-1).
REQ-005 The parameter FWFT SHALL default to 0, where 0 selects standard registered read and 1 selects first-word-fall-through.
REQ-006 The design SHALL have one clock and a synchronous, active-high reset, with ports listed as follows.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 clear  in  1  synchronous flush; lower priority than reset.
REQ-010 wr_en  in  1  write request.
REQ-011 data_in  in  WIDTH  write data.
REQ-012 rd_en  in  1  read request (in FWFT mode, acknowledges the head word).
REQ-013 data_out  out  WIDTH  read data.
REQ-014 full / empty  out  1 each  occupancy flags.
REQ-015 almost_full / almost_empty  out  1 each  threshold flags.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow / underflow  out  1 each  one-cycle error pulses.

Function
REQ-018 The read accept signal SHALL be rd_acc = rd_en && !empty.
REQ-019 The write accept signal SHALL be wr_acc = wr_en && (!full || rd_en), so that a write to a full FIFO succeeds when a read occurs in the same cycle.
REQ-020 On wr_acc, data_in SHALL be stored at write_ptr, and write_ptr SHALL advance modulo DEPTH.
REQ-021 On rd_acc, read_ptr SHALL advance modulo DEPTH.
REQ-022 Pointers SHALL be $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit.
REQ-023 count SHALL update each cycle as follows: +1 on wr_acc only, -1 on rd_acc only, and hold on both or neither.
REQ-024 Flags SHALL be decoded from registered state as follows: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH).
REQ-025 Every flag SHALL reflect an accepted operation in the cycle after the accepting edge.
REQ-026 When FWFT=0, on rd_acc data_out SHALL load the entry at read_ptr, visible one cycle after the edge, and SHALL hold its value otherwise.
REQ-027 When FWFT=1, data_out SHALL equal the head entry whenever empty=0, with zero-cycle latency.
REQ-028 When FWFT=1 and empty=1, data_out SHALL hold the last value it presented.
REQ-029 A word written into an empty FIFO SHALL appear on data_out in FWFT mode in the cycle after the write edge.
REQ-030 overflow SHALL pulse high for exactly one cycle after any cycle with wr_en && !wr_acc, and the data SHALL be discarded.
REQ-031 underflow SHALL pulse high for exactly one cycle after any cycle with rd_en && empty, and no state SHALL change for that read.
REQ-032 When clear=1, pointers and count SHALL be set to 0 and overflow/underflow SHALL be set to 0.
REQ-033 When clear=1, data_out SHALL be held, and any wr_en or rd_en in the same cycle SHALL be ignored.
REQ-034 Storage SHALL be a register array; it SHALL not be reset, and its contents SHALL be unobservable until written.

Reset
REQ-035 When reset=1 at a clock edge, read_ptr, write_ptr, count, data_out, overflow and underflow SHALL be set to 0.
REQ-036 After reset, empty and almost_empty SHALL be 1, and full and almost_full SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL take effect on the next edge, regardless of wr_en, rd_en or clear.
REQ-038 Any data present at reset SHALL be lost.

Verification
REQ-039 Defaults: after reset, write 16 words 0x00..0x0F -> count=16 and full=1, with almost_full=1 from count=14; a 17th write gives overflow=1 for one cycle and count stays 16.
REQ-040 Defaults, FWFT=0: from the full state, 16 reads -> data_out = 0x00..0x0F each one cycle after its read, then empty=1; a further read gives underflow=1 for one cycle.
REQ-041 Full FIFO with wr_en=rd_en=1 and data_in=0xAA -> count stays 16, no overflow; 0xAA is read out after the 15 older words.
REQ-042 FWFT=1: write 0x5C to an empty FIFO -> the next cycle empty=0 and data_out=0x5C with rd_en=0; assert rd_en -> empty=1 the next cycle.
REQ-043 Wrap-around: 40 cycles of interleaved single write/read with incrementing data -> data_out sequence matches input and count never exceeds 1.
REQ-044 Load 5 words, pulse clear together with wr_en=1 -> count=0 and empty=1 the next cycle, and no write is accepted; the same sequence with reset in place of clear additionally sets data_out=0.
